// File: rtl/axi_wr_rsp_gen_pkg.sv
// Shared AXI write-response definitions: response codes and the B-beat record
// that travels through the completion queue and the output register.
package axi_wr_rsp_gen_pkg;

  // BID on the bus is always four bits wide; narrower IDs are zero-extended.
  localparam int BID_W = 4;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic [BID_W-1:0] id;
    axi_resp_e        resp;
    logic             user;
  } b_beat_t;

  localparam int B_BEAT_W = $bits(b_beat_t);

  // Builds a B beat from raw completion fields; the response code is passed through untouched.
  function automatic b_beat_t make_beat(input logic [BID_W-1:0] id,
                                        input logic [1:0]       resp,
                                        input logic             user);
    b_beat_t beat;
    beat.id   = id;
    beat.resp = axi_resp_e'(resp);
    beat.user = user;
    return beat;
  endfunction

endpackage

// File: rtl/axi_wr_rsp_gen_if.sv
// Completion-in / AXI B-channel-out bundle. The slave modport is the response
// generator's view; the master modport is the view of whoever drives completions
// and consumes B beats.
interface axi_wr_rsp_gen_if
  import axi_wr_rsp_gen_pkg::*;
#(
  parameter int ID_WIDTH = 4
);

  logic                cmpl_valid;
  logic                cmpl_ready;
  logic [ID_WIDTH-1:0] cmpl_id;
  logic [1:0]          cmpl_resp;
  logic                cmpl_user;

  logic                bvalid;
  logic                bready;
  logic [BID_W-1:0]    bid;
  logic [1:0]          bresp;
  logic                buser;

  modport slave (
    input  cmpl_valid, cmpl_id, cmpl_resp, cmpl_user, bready,
    output cmpl_ready, bvalid, bid, bresp, buser
  );

  modport master (
    output cmpl_valid, cmpl_id, cmpl_resp, cmpl_user, bready,
    input  cmpl_ready, bvalid, bid, bresp, buser
  );

endinterface

// File: rtl/axi_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. Read data is the current head
// (show-ahead), so a pop and the use of its data happen in the same cycle.
module axi_sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Full when the index bits match but the wrap bits differ; empty when both match.
  always_comb begin
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty   = (wr_ptr_q == rd_ptr_q);
    count   = wr_ptr_q - rd_ptr_q;
    rd_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Advance pointers only on legal pushes/pops so misuse cannot corrupt the state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en && !full) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axi_wr_rsp_gen.sv
// AXI write-response generator: queues burst completions and presents them on
// the B channel in acceptance order from a registered output stage. An empty
// queue is bypassed so a lone completion appears on B the very next cycle.
module axi_wr_rsp_gen
  import axi_wr_rsp_gen_pkg::*;
#(
  parameter int  ID_WIDTH = 4,
  parameter int  DEPTH    = 4,
  localparam int PEND_W   = $clog2(DEPTH) + 2,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  axi_wr_rsp_gen_if.slave   bus,
  output logic [PEND_W-1:0] pending
);

  logic [BID_W-1:0]    id_ext;
  b_beat_t             in_beat;
  logic                accept;
  logic                handshake;
  logic                out_free;

  logic                fifo_wr;
  logic                fifo_rd;
  logic                fifo_full;
  logic                fifo_empty;
  logic [B_BEAT_W-1:0] fifo_head;
  logic [CNT_W-1:0]    fifo_count;

  logic                out_valid_q, out_valid_d;
  b_beat_t             out_beat_q, out_beat_d;

  // Zero-extend the completion ID to the bus BID width and pack the incoming beat.
  always_comb begin
    id_ext                 = '0;
    id_ext[ID_WIDTH-1:0]   = bus.cmpl_id;
    in_beat                = make_beat(id_ext, bus.cmpl_resp, bus.cmpl_user);
  end

  axi_sync_fifo #(
    .WIDTH (B_BEAT_W),
    .DEPTH (DEPTH)
  ) u_cmpl_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (in_beat),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Output-register refill: the queue head has priority, otherwise a fresh completion bypasses the queue.
  always_comb begin
    accept      = bus.cmpl_valid && !fifo_full;
    handshake   = out_valid_q && bus.bready;
    out_free    = !out_valid_q || handshake;
    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    fifo_rd     = 1'b0;
    fifo_wr     = accept;
    if (out_free) begin
      if (!fifo_empty) begin
        out_valid_d = 1'b1;
        out_beat_d  = b_beat_t'(fifo_head);
        fifo_rd     = 1'b1;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_beat_d  = in_beat;
        fifo_wr     = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // B-channel output register; reset drops any in-flight beat immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_beat_q  <= out_beat_d;
    end
  end

  assign bus.cmpl_ready = !fifo_full;
  assign bus.bvalid     = out_valid_q;
  assign bus.bid        = out_beat_q.id;
  assign bus.bresp      = out_beat_q.resp;
  assign bus.buser      = out_beat_q.user;
  assign pending        = PEND_W'(fifo_count) + PEND_W'(out_valid_q);

endmodule
